// File: rtl/rv_dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: sequencer states, op codes,
// wait-state counter sizing and the value returned by a rejected load.
// Optional feature macro: URV_DMEM_BOUNDS_CHECK_EN (see rv_dmem_responder.sv).
package rv_dmem_responder_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StWait   = 2'd1,
        StAccess = 2'd2,
        StResp   = 2'd3
    } dmem_state_e;

    typedef enum logic {
        OpLoad  = 1'b0,
        OpStore = 1'b1
    } dmem_op_e;

    localparam logic [31:0] BusErrLoadValue = 32'h0000_0000;

    // Wait states are limited to 0..255
    localparam int unsigned WaitCntWidth = 8;

    // Counter preload: the WAIT state lasts exactly ws cycles when it runs down to zero
    function automatic logic [WaitCntWidth-1:0] wait_cnt_init(input int unsigned ws);
        return (ws > 0) ? WaitCntWidth'(ws - 1) : '0;
    endfunction

endpackage

// File: rtl/rv_dmem_ram.sv
// Single-port synchronous RAM, 32-bit words with per-byte write enables.
// Read data is registered and only updates on a read, so it holds between loads.
module rv_dmem_ram #(
    parameter int unsigned g_addr_width = 12
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic [g_addr_width-1:0] addr_i,
    input  logic [31:0]             wdata_i,
    input  logic [3:0]              we_i,
    input  logic                    re_i,
    output logic [31:0]             rdata_o
);

    localparam int unsigned Depth = 1 << g_addr_width;

    logic [31:0] mem_q [Depth];
    logic [31:0] rdata_q;

    // Byte-lane writes; storage itself is never reset
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (we_i[b]) begin
                mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    // Registered read port, cleared on reset so the load data output starts at zero
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/rv_dmem_responder.sv
// Data-memory responder: accepts load/store requests from the core, inserts a
// programmable number of wait states, accesses the RAM and returns a one-cycle
// done pulse. Flags protocol misuse in a sticky error bit.
// Optional feature: define URV_DMEM_BOUNDS_CHECK_EN to reject out-of-range
// addresses (store suppressed, load returns zero, dm_bus_err_o pulses with done).
module rv_dmem_responder
    import rv_dmem_responder_pkg::*;
#(
    parameter int unsigned g_addr_width  = 12,
    parameter int unsigned g_wait_states = 1
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_data_s_i,
    input  logic [3:0]  dm_data_select_i,
    input  logic        dm_store_i,
    input  logic        dm_load_i,
    output logic        dm_ready_o,
    output logic [31:0] dm_data_l_o,
    output logic        dm_load_done_o,
    output logic        dm_store_done_o,
    output logic        dm_proto_err_o,
    output logic        dm_bus_err_o
);

    localparam logic [WaitCntWidth-1:0] WaitInit = wait_cnt_init(g_wait_states);

    dmem_state_e             state_q;
    dmem_op_e                op_q;
    logic [WaitCntWidth-1:0] cnt_q;
    logic [g_addr_width-1:0] addr_q;
    logic [31:0]             wdata_q;
    logic [3:0]              sel_q;
    logic                    load_done_q;
    logic                    store_done_q;
    logic                    proto_err_q;

    logic                    req;
    logic                    busy;
    logic [3:0]              ram_we;
    logic                    ram_re;
    logic [31:0]             ram_rdata;

    // Byte-offset bits are never used; upper bits only matter with the bounds check
    logic                    unused_addr_bits;
    assign unused_addr_bits = ^{dm_addr_i[31:g_addr_width+2], dm_addr_i[1:0]};

`ifdef URV_DMEM_BOUNDS_CHECK_EN
    logic oob_d;
    logic oob_q;
    logic rd_zero_q;
    logic bus_err_q;

    assign oob_d = (dm_addr_i >> (g_addr_width + 2)) != 32'd0;
`endif

    assign req  = dm_load_i | dm_store_i;
    assign busy = (state_q == StWait) || (state_q == StAccess);

    // Sequencer: accept, wait-state countdown, RAM access, one-cycle response
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= StIdle;
            op_q         <= OpLoad;
            cnt_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            sel_q        <= '0;
            load_done_q  <= 1'b0;
            store_done_q <= 1'b0;
            proto_err_q  <= 1'b0;
`ifdef URV_DMEM_BOUNDS_CHECK_EN
            oob_q        <= 1'b0;
            rd_zero_q    <= 1'b0;
            bus_err_q    <= 1'b0;
`endif
        end else begin
            load_done_q  <= 1'b0;
            store_done_q <= 1'b0;
`ifdef URV_DMEM_BOUNDS_CHECK_EN
            bus_err_q    <= 1'b0;
`endif
            if (busy && req) begin
                proto_err_q <= 1'b1;
            end
            unique case (state_q)
                StIdle, StResp: begin
                    if (req) begin
                        // Store wins when both are requested
                        op_q    <= dm_store_i ? OpStore : OpLoad;
                        addr_q  <= dm_addr_i[g_addr_width+1:2];
                        wdata_q <= dm_data_s_i;
                        sel_q   <= dm_data_select_i;
                        if (dm_store_i && dm_load_i) begin
                            proto_err_q <= 1'b1;
                        end
`ifdef URV_DMEM_BOUNDS_CHECK_EN
                        oob_q   <= oob_d;
`endif
                        if (g_wait_states > 0) begin
                            state_q <= StWait;
                            cnt_q   <= WaitInit;
                        end else begin
                            state_q <= StAccess;
                        end
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StWait: begin
                    if (cnt_q == '0) begin
                        state_q <= StAccess;
                    end else begin
                        cnt_q <= cnt_q - WaitCntWidth'(1);
                    end
                end
                StAccess: begin
                    state_q <= StResp;
                    if (op_q == OpStore) begin
                        store_done_q <= 1'b1;
                    end else begin
                        load_done_q  <= 1'b1;
                    end
`ifdef URV_DMEM_BOUNDS_CHECK_EN
                    bus_err_q <= oob_q;
                    if (op_q == OpLoad) begin
                        rd_zero_q <= oob_q;
                    end
`endif
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // RAM strobes are decoded from the ACCESS state so a reset before it never writes
    always_comb begin
        ram_we = '0;
        ram_re = 1'b0;
        if (state_q == StAccess) begin
            if (op_q == OpStore) begin
                ram_we = sel_q;
            end else begin
                ram_re = 1'b1;
            end
`ifdef URV_DMEM_BOUNDS_CHECK_EN
            if (oob_q) begin
                ram_we = '0;
            end
`endif
        end
    end

    rv_dmem_ram #(
        .g_addr_width (g_addr_width)
    ) u_ram (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .addr_i  (addr_q),
        .wdata_i (wdata_q),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .rdata_o (ram_rdata)
    );

    assign dm_ready_o      = (state_q == StIdle) || (state_q == StResp);
    assign dm_load_done_o  = load_done_q;
    assign dm_store_done_o = store_done_q;
    assign dm_proto_err_o  = proto_err_q;

`ifdef URV_DMEM_BOUNDS_CHECK_EN
    assign dm_data_l_o  = rd_zero_q ? BusErrLoadValue : ram_rdata;
    assign dm_bus_err_o = bus_err_q;
`else
    assign dm_data_l_o  = ram_rdata;
    assign dm_bus_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_rv_dmem_responder.sv
// Bench for rv_dmem_responder: one instance with one wait state (A) and one with
// none (B) share stimulus. A table of single transactions runs on A, followed by
// hand-written sequences for reset-in-WAIT, back-to-back and protocol errors.
module tb_rv_dmem_responder;

`ifdef URV_DMEM_BOUNDS_CHECK_EN
    localparam bit BoundsEn = 1'b1;
`else
    localparam bit BoundsEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic        store;
    logic        load;

    logic        ra_ready, ra_ld_done, ra_st_done, ra_proto, ra_berr;
    logic [31:0] ra_data;
    logic        rb_ready, rb_ld_done, rb_st_done, rb_proto, rb_berr;
    logic [31:0] rb_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rv_dmem_responder #(
        .g_addr_width  (12),
        .g_wait_states (1)
    ) u_dut_a (
        .clk_i            (clk),
        .rst_n_i          (rst_n),
        .dm_addr_i        (addr),
        .dm_data_s_i      (wdata),
        .dm_data_select_i (sel),
        .dm_store_i       (store),
        .dm_load_i        (load),
        .dm_ready_o       (ra_ready),
        .dm_data_l_o      (ra_data),
        .dm_load_done_o   (ra_ld_done),
        .dm_store_done_o  (ra_st_done),
        .dm_proto_err_o   (ra_proto),
        .dm_bus_err_o     (ra_berr)
    );

    rv_dmem_responder #(
        .g_addr_width  (12),
        .g_wait_states (0)
    ) u_dut_b (
        .clk_i            (clk),
        .rst_n_i          (rst_n),
        .dm_addr_i        (addr),
        .dm_data_s_i      (wdata),
        .dm_data_select_i (sel),
        .dm_store_i       (store),
        .dm_load_i        (load),
        .dm_ready_o       (rb_ready),
        .dm_data_l_o      (rb_data),
        .dm_load_done_o   (rb_ld_done),
        .dm_store_done_o  (rb_st_done),
        .dm_proto_err_o   (rb_proto),
        .dm_bus_err_o     (rb_berr)
    );

    typedef struct {
        bit          st;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
        logic [31:0] exp_data;
        bit          exp_be;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Caller is #1 after a rising edge (cycle N). Issues one request in cycle N and
    // observes cycles N..N+8 on instance A or B; ends #1 after a rising edge.
    task automatic run_op(input bit use_b, input bit st, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s, input int exp_lat,
                          output int lat, output logic [31:0] dat_done,
                          output logic be_done, output bit rdy_ok, output bit bad_kind,
                          output logic [31:0] dat_end);
        logic rdy, dn, other;
        lat      = -1;
        rdy_ok   = 1'b1;
        bad_kind = 1'b0;
        dat_done = 'x;
        be_done  = 1'bx;
        addr  = a;
        wdata = d;
        sel   = s;
        store = st;
        load  = !st;
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
                store = 1'b0;
                load  = 1'b0;
            end
            @(negedge clk);
            rdy   = use_b ? rb_ready : ra_ready;
            dn    = use_b ? (st ? rb_st_done : rb_ld_done) : (st ? ra_st_done : ra_ld_done);
            other = use_b ? (st ? rb_ld_done : rb_st_done) : (st ? ra_ld_done : ra_st_done);
            if (k == 0) begin
                if (rdy !== 1'b1) rdy_ok = 1'b0;
            end else begin
                if (rdy !== (k >= exp_lat)) rdy_ok = 1'b0;
                if (dn === 1'b1) begin
                    lat      = (lat == -1) ? k : 99;
                    dat_done = use_b ? rb_data : ra_data;
                    be_done  = use_b ? rb_berr : ra_berr;
                end
                if (other !== 1'b0) bad_kind = 1'b1;
            end
        end
        dat_end = use_b ? rb_data : ra_data;
        @(posedge clk);
        #1;
    endtask

    task automatic check_op(input string tag, input bit use_b, input bit st,
                            input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int exp_lat, input logic [31:0] exp_data, input bit exp_be);
        int          lat;
        logic [31:0] dat_done, dat_end;
        logic        be_done;
        bit          rdy_ok, bad_kind;
        run_op(use_b, st, a, d, s, exp_lat, lat, dat_done, be_done, rdy_ok, bad_kind, dat_end);
        chk({tag, " done latency"}, 32'(lat), 32'(exp_lat));
        chk1({tag, " ready pattern"}, rdy_ok, 1'b1);
        chk1({tag, " no other done"}, bad_kind, 1'b0);
        chk({tag, " data at done"}, dat_done, exp_data);
        chk({tag, " data held"}, dat_end, exp_data);
        chk1({tag, " bus err at done"}, be_done, exp_be);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 32'h10,    32'hCAFEBABE, 4'hF, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 32'h10,    32'h0,        4'h0, 32'hCAFEBABE, 1'b0};
        vecs[2]  = '{1'b1, 32'h14,    32'h11223344, 4'hF, 32'hCAFEBABE, 1'b0};
        vecs[3]  = '{1'b1, 32'h14,    32'h000000AA, 4'h1, 32'hCAFEBABE, 1'b0};
        vecs[4]  = '{1'b0, 32'h14,    32'h0,        4'h0, 32'h112233AA, 1'b0};
        vecs[5]  = '{1'b1, 32'h14,    32'hFFFFFFFF, 4'h0, 32'h112233AA, 1'b0};
        vecs[6]  = '{1'b0, 32'h14,    32'h0,        4'h0, 32'h112233AA, 1'b0};
        vecs[7]  = '{1'b1, 32'h0,     32'h5A5A5A5A, 4'hF, 32'h112233AA, 1'b0};
        vecs[8]  = '{1'b1, 32'h18,    32'h01020304, 4'hF, 32'h112233AA, 1'b0};
        vecs[9]  = '{1'b1, 32'h18,    32'hDEAD0000, 4'hC, 32'h112233AA, 1'b0};
        vecs[10] = '{1'b0, 32'h18,    32'h0,        4'h0, 32'hDEAD0304, 1'b0};
        vecs[11] = '{1'b1, 32'h20,    32'h77665544, 4'hF, 32'hDEAD0304, 1'b0};
        vecs[12] = '{1'b0, 32'h10000, 32'h0,        4'h0,
                     BoundsEn ? 32'h0 : 32'h5A5A5A5A, BoundsEn};

        rst_n = 1'b0;
        addr  = '0;
        wdata = '0;
        sel   = '0;
        store = 1'b0;
        load  = 1'b0;
        #12;
        chk1("reset ready", ra_ready, 1'b1);
        chk("reset load data", ra_data, 32'h0);
        chk1("reset load done", ra_ld_done, 1'b0);
        chk1("reset store done", ra_st_done, 1'b0);
        chk1("reset proto err", ra_proto, 1'b0);
        chk1("reset bus err", ra_berr, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single transactions on A (one wait state): done lands three cycles after accept
        foreach (vecs[i]) begin
            check_op($sformatf("row%0d", i), 1'b0, vecs[i].st, vecs[i].addr, vecs[i].data,
                     vecs[i].sel, 3, vecs[i].exp_data, vecs[i].exp_be);
        end
        chk1("table proto err A", ra_proto, 1'b0);
        chk1("table proto err B", rb_proto, 1'b0);

        // Reset while A is in WAIT with a store to 0x20 pending
        addr  = 32'h20;
        wdata = 32'hBAD0BAD0;
        sel   = 4'hF;
        store = 1'b1;
        @(posedge clk);
        #1;
        store = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk1("midwait ready", ra_ready, 1'b1);
        chk1("midwait store done", ra_st_done, 1'b0);
        chk("midwait load data", ra_data, 32'h0);
        chk1("midwait proto err", ra_proto, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk1($sformatf("midwait no done %0d", k), ra_st_done | rb_st_done, 1'b0);
        end
        @(posedge clk);
        #1;
        check_op("reload 0x20", 1'b0, 1'b0, 32'h20, 32'h0, 4'h0, 3, 32'h77665544, 1'b0);

        // Back-to-back on B: load issued in the RESP cycle of a store
        addr  = 32'h30;
        wdata = 32'h12345678;
        sel   = 4'hF;
        store = 1'b1;
        @(posedge clk);
        #1;
        store = 1'b0;
        @(negedge clk);
        chk1("b2b store not yet done", rb_st_done, 1'b0);
        @(posedge clk);
        #1;
        load = 1'b1;
        @(negedge clk);
        chk1("b2b store done", rb_st_done, 1'b1);
        chk1("b2b ready in resp", rb_ready, 1'b1);
        @(posedge clk);
        #1;
        load = 1'b0;
        @(negedge clk);
        chk1("b2b load not yet done", rb_ld_done, 1'b0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk1("b2b load done", rb_ld_done, 1'b1);
        chk("b2b load data", rb_data, 32'h12345678);
        chk1("b2b proto err B", rb_proto, 1'b0);
        chk1("busy request proto err A", ra_proto, 1'b1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;

        // Request while B is not ready sets the sticky error
        addr = 32'h30;
        load = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk1("busy B not ready", rb_ready, 1'b0);
        @(posedge clk);
        #1;
        load = 1'b0;
        @(negedge clk);
        chk1("busy B proto err", rb_proto, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
        end
        @(negedge clk);
        chk1("busy B proto err sticky", rb_proto, 1'b1);

        // Reset clears the error; then load and store together: store wins, error set
        rst_n = 1'b0;
        #1;
        chk1("reset clears proto", rb_proto, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        addr  = 32'h34;
        wdata = 32'h0BADF00D;
        sel   = 4'hF;
        store = 1'b1;
        load  = 1'b1;
        @(posedge clk);
        #1;
        store = 1'b0;
        load  = 1'b0;
        @(negedge clk);
        chk1("both proto err", rb_proto, 1'b1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk1("both store done", rb_st_done, 1'b1);
        chk1("both load dropped", rb_ld_done, 1'b0);
        @(posedge clk);
        #1;
        check_op("both reload", 1'b1, 1'b0, 32'h34, 32'h0, 4'h0, 2, 32'h0BADF00D, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
